// File: rtl/sa_tile_sequencer.sv
// Tile-level control sequencer for the systolic-array datapath.
// One start pulse runs: weight load, weight push, activation load,
// skewed compute and result drain, then a one-cycle done pulse.
// Weight phases are skipped when reuse is requested and the array
// already holds a valid weight set.
module sa_tile_sequencer #(
  parameter  int ARRAY_W = 4,
  parameter  int DATA_W  = 8,
  parameter  int K_MAX   = 16,
  localparam int K_W     = $clog2(K_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           reuse_weight,
  input  logic [K_W-1:0] k_len,
  input  logic           wgt_valid,
  output logic           wgt_ready,
  input  logic           act_valid,
  output logic           act_ready,
  input  logic           res_ready,
  output logic           res_valid,
  output logic           weight_buffer_load_en,
  output logic           weight_buffer_out_en,
  output logic           write_weight_en,
  output logic           input_buffer_load_en,
  output logic           input_buffer_out_en,
  output logic           output_buffer_load_en,
  output logic           output_buffer_out_en,
  output logic           busy,
  output logic           done,
  output logic           err
);

  // Counter must hold kl + 2*ARRAY_W without wrapping.
  localparam int CW = $clog2(K_MAX + 2 * ARRAY_W + 1);
  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] AW_M1 = CW'(ARRAY_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WLOAD   = 3'd1,
    S_WPUSH   = 3'd2,
    S_ALOAD   = 3'd3,
    S_COMPUTE = 3'd4,
    S_DRAIN   = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [K_W-1:0] kl;
  logic           wvalid;

  // Terminal counts derived from the latched row count.
  logic [CW-1:0] kl_c;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] tc_act;
  logic [CW-1:0] tc_comp;
  logic [CW-1:0] tc_drain;
  logic [CW-1:0] feed_lim;

  assign kl_c     = CW'(kl);
  assign cnt_nx   = cnt + ONE;
  assign tc_act   = kl_c - ONE;
  assign tc_comp  = kl_c + CW'(2 * ARRAY_W - 3);
  assign tc_drain = kl_c + CW'(ARRAY_W - 2);
  assign feed_lim = kl_c + CW'(ARRAY_W - 1);

  // Handshake strobes are the only combinational outputs.
  assign weight_buffer_load_en = wgt_valid & wgt_ready;
  assign input_buffer_load_en  = act_valid & act_ready;
  assign output_buffer_out_en  = res_valid & res_ready;

  // Tile FSM: state, counters and registered enables for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      cnt                   <= ZERO;
      kl                    <= {K_W{1'b0}};
      wvalid                <= 1'b0;
      wgt_ready             <= 1'b0;
      act_ready             <= 1'b0;
      res_valid             <= 1'b0;
      weight_buffer_out_en  <= 1'b0;
      write_weight_en       <= 1'b0;
      input_buffer_out_en   <= 1'b0;
      output_buffer_load_en <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      err                   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kl   <= k_len;
            cnt  <= ZERO;
            busy <= 1'b1;
            if ((k_len == {K_W{1'b0}}) || (k_len > K_W'(K_MAX))) begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (reuse_weight && wvalid) begin
              state     <= S_ALOAD;
              act_ready <= 1'b1;
            end else begin
              wvalid    <= 1'b0;
              state     <= S_WLOAD;
              wgt_ready <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WLOAD: begin
          if (wgt_valid) begin
            if (cnt == AW_M1) begin
              cnt                  <= ZERO;
              state                <= S_WPUSH;
              wgt_ready            <= 1'b0;
              weight_buffer_out_en <= 1'b1;
              write_weight_en      <= 1'b1;
            end else begin
              cnt <= cnt_nx;
            end
          end else begin
            cnt <= cnt;
          end
        end
        S_WPUSH: begin
          if (cnt == AW_M1) begin
            cnt                  <= ZERO;
            wvalid               <= 1'b1;
            state                <= S_ALOAD;
            weight_buffer_out_en <= 1'b0;
            write_weight_en      <= 1'b0;
            act_ready            <= 1'b1;
          end else begin
            cnt <= cnt_nx;
          end
        end
        S_ALOAD: begin
          if (act_valid) begin
            if (cnt == tc_act) begin
              cnt                   <= ZERO;
              state                 <= S_COMPUTE;
              act_ready             <= 1'b0;
              input_buffer_out_en   <= 1'b1;
              output_buffer_load_en <= (AW_M1 == ZERO);
            end else begin
              cnt <= cnt_nx;
            end
          end else begin
            cnt <= cnt;
          end
        end
        S_COMPUTE: begin
          // cnt is the compute index c; enables are prepared for c+1.
          if (cnt == tc_comp) begin
            cnt                   <= ZERO;
            state                 <= S_DRAIN;
            input_buffer_out_en   <= 1'b0;
            output_buffer_load_en <= 1'b0;
            res_valid             <= 1'b1;
          end else begin
            cnt                   <= cnt_nx;
            input_buffer_out_en   <= (cnt_nx < feed_lim);
            output_buffer_load_en <= (cnt_nx >= AW_M1);
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (cnt == tc_drain) begin
              cnt       <= ZERO;
              state     <= S_FIN;
              res_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt_nx;
            end
          end else begin
            cnt <= cnt;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state                 <= S_IDLE;
          cnt                   <= ZERO;
          wgt_ready             <= 1'b0;
          act_ready             <= 1'b0;
          res_valid             <= 1'b0;
          weight_buffer_out_en  <= 1'b0;
          write_weight_en       <= 1'b0;
          input_buffer_out_en   <= 1'b0;
          output_buffer_load_en <= 1'b0;
          busy                  <= 1'b0;
          done                  <= 1'b0;
          err                   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Directed testbench for sa_tile_sequencer (ARRAY_W=4, K_MAX=16).
module tb_sa_tile_sequencer;

  localparam int ARRAY_W = 4;
  localparam int DATA_W  = 8;
  localparam int K_MAX   = 16;
  localparam int K_W     = $clog2(K_MAX + 1);

  logic           clk = 1'b0;
  logic           rst, start, reuse_weight;
  logic [K_W-1:0] k_len;
  logic           wgt_valid, act_valid, res_ready;
  logic           wgt_ready, act_ready, res_valid;
  logic           weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic           input_buffer_load_en, input_buffer_out_en;
  logic           output_buffer_load_en, output_buffer_out_en;
  logic           busy, done, err;

  int vectors = 0;
  int errors  = 0;

  sa_tile_sequencer #(.ARRAY_W(ARRAY_W), .DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_weight(reuse_weight), .k_len(k_len),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .act_valid(act_valid), .act_ready(act_ready),
    .res_ready(res_ready), .res_valid(res_valid),
    .weight_buffer_load_en(weight_buffer_load_en),
    .weight_buffer_out_en(weight_buffer_out_en),
    .write_weight_en(write_weight_en),
    .input_buffer_load_en(input_buffer_load_en),
    .input_buffer_out_en(input_buffer_out_en),
    .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en(output_buffer_out_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [12:0] all_outs;
  assign all_outs = {wgt_ready, act_ready, res_valid, weight_buffer_load_en,
                     weight_buffer_out_en, write_weight_en, input_buffer_load_en,
                     input_buffer_out_en, output_buffer_load_en, output_buffer_out_en,
                     busy, done, err};

  // Event counters: index order wbl,wbo,wwe,ibl,ibo,obl,obo,done,err,busy,wrdy
  localparam int NC = 11;
  int    cnt_now [NC];
  int    cnt_base[NC];
  string nm[NC] = '{"wbl", "wbo", "wwe", "ibl", "ibo", "obl", "obo", "done", "err", "busy", "wrdy"};

  initial for (int i = 0; i < NC; i++) cnt_now[i] = 0;

  // Count cycles in which each output is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (weight_buffer_load_en) cnt_now[0]++;
    if (weight_buffer_out_en)  cnt_now[1]++;
    if (write_weight_en)       cnt_now[2]++;
    if (input_buffer_load_en)  cnt_now[3]++;
    if (input_buffer_out_en)   cnt_now[4]++;
    if (output_buffer_load_en) cnt_now[5]++;
    if (output_buffer_out_en)  cnt_now[6]++;
    if (done)                  cnt_now[7]++;
    if (err)                   cnt_now[8]++;
    if (busy)                  cnt_now[9]++;
    if (wgt_ready)             cnt_now[10]++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < NC; i++) cnt_base[i] = cnt_now[i];
  endtask

  function automatic int d(input int i);
    return cnt_now[i] - cnt_base[i];
  endfunction

  task automatic start_tile(input int k, input logic reuse);
    k_len        = K_W'(k);
    reuse_weight = reuse;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", tag, done, i);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (all_outs !== 13'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b required 0", all_outs);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (all_outs !== 13'd0) begin
      errors++;
      $display("FAIL reset idle_outputs: got %b required 0", all_outs);
    end
  endtask

  task automatic test_full_tile();
    int exp_d[NC] = '{4, 4, 4, 4, 7, 7, 7, 1, 0, 30, 4};
    int i = 0;
    snap();
    start_tile(4, 1'b0);
    vectors++;
    if (busy !== 1'b1 || wgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL tile1 enter_wload: busy=%b wgt_ready=%b required 1 1", busy, wgt_ready);
    end
    while (input_buffer_out_en !== 1'b1 && i < 60) begin
      step();
      i++;
    end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (input_buffer_out_en !== (c < 7) || output_buffer_load_en !== (c >= 3)) begin
        errors++;
        $display("FAIL tile1 compute_c%0d: ibo=%b obl=%b required %b %b",
                 c, input_buffer_out_en, output_buffer_load_en, c < 7, c >= 3);
      end
      step();
    end
    vectors++;
    if (res_valid !== 1'b1 || input_buffer_out_en !== 1'b0 || output_buffer_load_en !== 1'b0) begin
      errors++;
      $display("FAIL tile1 drain_entry: res_valid=%b ibo=%b obl=%b required 1 0 0",
               res_valid, input_buffer_out_en, output_buffer_load_en);
    end
    run_until_done("tile1", 60);
    for (int j = 0; j < NC; j++) begin
      vectors++;
      if (d(j) !== exp_d[j]) begin
        errors++;
        $display("FAIL tile1 %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
      end
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL tile1 after_done: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reuse();
    int exp_d[NC] = '{0, 0, 0, 2, 5, 5, 5, 1, 0, 16, 0};
    snap();
    start_tile(2, 1'b1);
    vectors++;
    if (act_ready !== 1'b1 || wgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reuse enter_aload: act_ready=%b wgt_ready=%b required 1 0", act_ready, wgt_ready);
    end
    run_until_done("reuse", 60);
    for (int j = 0; j < NC; j++) begin
      vectors++;
      if (d(j) !== exp_d[j]) begin
        errors++;
        $display("FAIL reuse %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
      end
    end
  endtask

  task automatic test_reuse_after_reset();
    int exp_d[NC] = '{4, 4, 4, 1, 4, 4, 4, 1, 0, 21, 4};
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    snap();
    start_tile(1, 1'b1);
    vectors++;
    if (wgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL reuse_rst enter_wload: wgt_ready=%b required 1", wgt_ready);
    end
    run_until_done("reuse_rst", 60);
    for (int j = 0; j < NC; j++) begin
      vectors++;
      if (d(j) !== exp_d[j]) begin
        errors++;
        $display("FAIL reuse_rst %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_d[NC] = '{4, 4, 4, 4, 7, 7, 7, 1, 0, -1, -1};
    int stall = 0;
    int i = 0;
    snap();
    wgt_valid = 1'b0;
    start_tile(4, 1'b0);
    while (done !== 1'b1 && i < 300) begin
      wgt_valid = ~wgt_valid;
      if (res_valid === 1'b1 && d(6) == 2 && stall < 3) begin
        res_ready = 1'b0;
        stall++;
      end else begin
        res_ready = 1'b1;
      end
      step();
      i++;
      if (res_ready === 1'b0) begin
        vectors++;
        if (res_valid !== 1'b1) begin
          errors++;
          $display("FAIL backpressure stall_hold: res_valid=%b required 1", res_valid);
        end
      end
    end
    wgt_valid = 1'b1;
    res_ready = 1'b1;
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure done_timeout: done=%b required 1", done);
    end
    step();
    vectors++;
    if (stall !== 3) begin
      errors++;
      $display("FAIL backpressure stall_cycles: got %0d required 3", stall);
    end
    for (int j = 0; j < NC; j++) begin
      if (exp_d[j] >= 0) begin
        vectors++;
        if (d(j) !== exp_d[j]) begin
          errors++;
          $display("FAIL backpressure %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
        end
      end
    end
  endtask

  task automatic test_bad_k();
    int bad[2] = '{0, K_MAX + 1};
    int exp_d[NC] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    for (int b = 0; b < 2; b++) begin
      snap();
      start_tile(bad[b], 1'b0);
      vectors++;
      if (done !== 1'b1 || err !== 1'b1) begin
        errors++;
        $display("FAIL bad_k%0d pulse: done=%b err=%b required 1 1", bad[b], done, err);
      end
      step();
      vectors++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_k%0d after: done=%b err=%b busy=%b required 0 0 0", bad[b], done, err, busy);
      end
      for (int j = 0; j < NC; j++) begin
        vectors++;
        if (d(j) !== exp_d[j]) begin
          errors++;
          $display("FAIL bad_k%0d %s: got %0d required %0d", bad[b], nm[j], d(j), exp_d[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    int exp_d[NC] = '{4, 4, 4, 2, 5, 5, 5, 1, 0, 24, 4};
    int i = 0;
    snap();
    start_tile(4, 1'b0);
    while (input_buffer_out_en !== 1'b1 && i < 60) begin
      step();
      i++;
    end
    vectors++;
    if (input_buffer_out_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid reach_compute: ibo=%b required 1", input_buffer_out_en);
    end
    step();
    step();
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (all_outs !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid outputs: got %b required 0", all_outs);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (d(7) !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid no_done: done_count=%0d busy=%b required 0 0", d(7), busy);
    end
    snap();
    start_tile(2, 1'b1);
    run_until_done("rst_mid_next", 80);
    for (int j = 0; j < NC; j++) begin
      vectors++;
      if (d(j) !== exp_d[j]) begin
        errors++;
        $display("FAIL rst_mid_next %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
      end
    end
  endtask

  task automatic test_start_in_drain();
    int exp_d[NC] = '{0, 0, 0, 2, 5, 5, 5, 1, 0, 16, 0};
    int i = 0;
    int busy_hi = 0;
    snap();
    start_tile(2, 1'b1);
    while (res_valid !== 1'b1 && i < 60) begin
      step();
      i++;
    end
    k_len        = K_W'(4);
    reuse_weight = 1'b0;
    start        = 1'b1;
    step();
    start        = 1'b0;
    run_until_done("drain_start", 60);
    for (int j = 0; j < NC; j++) begin
      vectors++;
      if (d(j) !== exp_d[j]) begin
        errors++;
        $display("FAIL drain_start %s: got %0d required %0d", nm[j], d(j), exp_d[j]);
      end
    end
    for (int c = 0; c < 5; c++) begin
      if (busy === 1'b1 || done === 1'b1) busy_hi++;
      step();
    end
    vectors++;
    if (busy_hi !== 0) begin
      errors++;
      $display("FAIL drain_start idle_after: busy/done cycles=%0d required 0", busy_hi);
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    reuse_weight = 1'b0;
    k_len        = '0;
    wgt_valid    = 1'b1;
    act_valid    = 1'b1;
    res_ready    = 1'b1;
    test_reset();
    test_full_tile();
    test_reuse();
    test_reuse_after_reset();
    test_backpressure();
    test_bad_k();
    test_reset_mid_compute();
    test_start_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Parametrised control sequencer for the systolic-array datapath.
- Replaces the seven buffer/array enables that are currently driven by hand. It runs one tile per `start` pulse:
  - weight load, then weight push into the array,
  - activation load, then skewed compute,
  - output drain, with valid/ready on all external data streams.
- Optional weight-reuse mode skips reloading when the array already holds valid weights.

Parameters:
- ARRAY_W, 4, array rows = columns; sets beat counts.
- DATA_W, 8, element width; activation and weight buses are ARRAY_W*DATA_W bits.
- K_MAX, 16, maximum activation rows per tile.
- K_W, derived localparam = $clog2(K_MAX+1), width of `k_len`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  tile start pulse; sampled only in IDLE
- reuse_weight  in  1  sampled with start; skip weight phases if weights are valid
- k_len  in  K_W  activation rows this tile; latched at start
- wgt_valid  in  1  weight row offered
- wgt_ready  out  1  sequencer accepts weight row
- act_valid  in  1  activation row offered
- act_ready  out  1  sequencer accepts activation row
- res_ready  in  1  downstream accepts result row
- res_valid  out  1  result row valid on output buffer
- weight_buffer_load_en  out  1  = wgt_valid & wgt_ready
- weight_buffer_out_en  out  1  weight buffer shift-out
- write_weight_en  out  1  array weight-latch enable
- input_buffer_load_en  out  1  = act_valid & act_ready
- input_buffer_out_en  out  1  activation feed into array
- output_buffer_load_en  out  1  capture array sums
- output_buffer_out_en  out  1  = res_valid & res_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile end
- err  out  1  one-cycle pulse with done on bad k_len

Behaviour:
- Reset: state goes to IDLE; all outputs are 0; counters are 0; the internal `wvalid` flag is cleared. Reset asserted mid-tile aborts immediately, with no done pulse.
- IDLE, on start:
  - Latch k_len (`kl`).
  - If kl==0 or kl>K_MAX, go to FIN with err=1.
  - Otherwise, if reuse_weight & wvalid, go to ALOAD.
  - Otherwise clear wvalid and go to WLOAD.
- start while busy is ignored.
- WLOAD:
  - wgt_ready=1.
  - Count handshakes; after ARRAY_W handshakes go to WPUSH. wgt_ready drops the cycle after the last beat.
  - wgt_valid=0 stalls indefinitely.
- WPUSH: weight_buffer_out_en=1 and write_weight_en=1 for exactly ARRAY_W cycles. Then set wvalid and go to ALOAD.
- ALOAD: act_ready=1; after kl handshakes go to COMPUTE.
- COMPUTE: lasts exactly kl+2*ARRAY_W-2 cycles, indexed c=0.. from entry.
  - input_buffer_out_en=1 for c < kl+ARRAY_W-1.
  - output_buffer_load_en=1 for c >= ARRAY_W-1.
  - Both are high in the overlap.
  - Then go to DRAIN.
- DRAIN:
  - res_valid=1.
  - Count handshakes; after kl+ARRAY_W-1 beats go to FIN.
  - res_ready low holds res_valid high with no count advance.
- FIN: done=1 (err=1 if the bad-k path was taken) for one cycle, then return to IDLE.
- Counters must be wide enough for kl+2*ARRAY_W. Compare exact equality to terminal count; no wrap-around is allowed.
- All enable outputs are registered-state decodes or the listed handshake ANDs; no other combinational paths from inputs.
- wvalid persists across tiles until reset or a new non-reuse tile.

Test Plan:
1. ARRAY_W=4, k_len=4, all valids/readies high:
   - 4 weight beats, then 4 cycles WPUSH, 4 act beats, 10 cycles COMPUTE.
   - input_buffer_out_en high in c0-6; output_buffer_load_en high in c3-9.
   - 7 drain beats, then done pulse.
   - busy high throughout, 0 after done.
2. Second tile with reuse_weight=1, k_len=2: no wgt_ready assertion; go straight to ALOAD; 8 COMPUTE cycles; 5 drain beats; done. Third tile with reuse_weight=1 directly after reset: WLOAD still occurs.
3. Backpressure: wgt_valid toggles every other cycle, and res_ready is low 3 cycles mid-drain. Beat counts stay exact; res_valid stays high while stalled; no extra output_buffer_out_en pulses.
4. k_len=0 and k_len=K_MAX+1: done and err pulse together one cycle after start; no buffer enable ever asserts.
5. rst asserted in COMPUTE cycle 3: next cycle all outputs are 0 and state is IDLE with no done. A following reuse_weight=1 tile performs WLOAD.
6. start pulsed during DRAIN is ignored: exactly one done pulse, and busy stays 0 afterwards.
